// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC register / instruction-fetch sequencer.
package pc_fetch_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      VALID = 2'd2,
      FAULT = 2'd3
   } fetch_state_e;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int          DEFAULT_ADDR_W   = 10;
   localparam int          DEFAULT_TIMEOUT  = 255;

   // A PC is fetchable only when every bit above the imem word-address width is zero.
   function automatic logic pcInRange(input logic [31:0] pc, input int addrW);
      return (pc >> addrW) == 32'd0;
   endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bus between the fetch sequencer and imem.
interface pc_fetch_if #(
   parameter int ADDR_W = 10
);
   logic              ImemReq;
   logic [ADDR_W-1:0] ImemAddr;
   logic              ImemGnt;
   logic              ImemRvalid;
   logic [31:0]       ImemRdata;
   logic              ImemErr;

   modport master (
      output ImemReq, ImemAddr,
      input  ImemGnt, ImemRvalid, ImemRdata, ImemErr
   );

   modport slave (
      input  ImemReq, ImemAddr,
      output ImemGnt, ImemRvalid, ImemRdata, ImemErr
   );
endinterface

// File: rtl/pc_fetch_timer.sv
// Saturating 8-bit response timer; expired_o flags that TIMEOUT cycles have elapsed.
module fetch_timer #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   logic [7:0] count_q;
   logic [7:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = 8'd0;
      end else if (en_i && (count_q != 8'hFF)) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = (count_q == TIMEOUT);

endmodule

// File: rtl/pc_fetch.sv
// PC register and instruction-fetch FSM; loads NPC only when the datapath retires
// a valid instruction and faults permanently on bad addresses, errors or timeouts.
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          ADDR_W   = DEFAULT_ADDR_W,
   parameter int          TIMEOUT  = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       NPC,
   input  logic              Advance,
   pc_fetch_if.master        imem,
   output logic [31:0]       PC,
   output logic [31:0]       Instr,
   output logic              InstrValid,
   output logic              Fault
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic         reqComb;
   logic         timerClr;
   logic         timerEn;
   logic         timerExpired;

   fetch_timer #(
      .TIMEOUT (TIMEOUT_C)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (timerClr),
      .en_i      (timerEn),
      .expired_o (timerExpired)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      reqComb  = 1'b0;
      timerClr = 1'b0;
      timerEn  = 1'b0;
      case (state_q)
         FETCH: begin
            if (!pcInRange(pc_q, ADDR_W)) begin
               state_d = FAULT;
            end else begin
               reqComb = 1'b1;
               if (imem.ImemGnt) begin
                  state_d  = WAIT;
                  timerClr = 1'b1;
               end
            end
         end
         WAIT: begin
            timerEn = 1'b1;
            // A response beats the timeout when both land in the same cycle.
            if (imem.ImemRvalid) begin
               if (imem.ImemErr) begin
                  state_d = FAULT;
               end else begin
                  instr_d = imem.ImemRdata;
                  state_d = VALID;
               end
            end else if (timerExpired) begin
               state_d = FAULT;
            end
         end
         VALID: begin
            // Retiring to the same PC is a self-loop: keep the instruction, skip the refetch.
            if (Advance && (NPC != pc_q)) begin
               pc_d    = NPC;
               state_d = FETCH;
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = FAULT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         instr_q <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign imem.ImemReq  = reqComb && !rst;
   assign imem.ImemAddr = pc_q[ADDR_W-1:0];
   assign PC            = pc_q;
   assign Instr         = instr_q;
   assign InstrValid    = (state_q == VALID);
   assign Fault         = (state_q == FAULT);

endmodule
